balik_dagitici: RTL and testbench

BALIK_DAGITICI -- requirements
Module: balik_dagitici

---
 rtl/balik_dagitici.sv | 164 ++++++++++++++++
 tb/tb_balik_dagitici.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/balik_dagitici.sv
// balik_dagitici: round-robin distributor of a shared fish pool among four
// penguins. Each cycle in the distributing state, at most one hungry,
// requesting penguin is granted one portion. A penguin whose stomach would
// reach the threshold is marked full instead of being fed. Stomachs digest
// periodically, and the block finishes once all four penguins are full.
//
// Ports:
//   saat        clock; all state changes on the rising edge
//   reset       synchronous, active-high reset
//   istek[3:0]  per-penguin feed request
//   porsiyon    portion size for this cycle's grant (0..7)
//   stok_yukle  add stok_deger to the pool this cycle
//   stok_deger  amount loaded when stok_yukle is high
//   izin        registered one-hot grant, 0 when no grant
//   tok         registered per-penguin full flags, sticky until reset
//   stok        registered remaining pool (saturates at 255)
//   bitti       registered, high once every penguin is full
//   bitme_sure  number of cycles spent distributing, saturating at 255
module balik_dagitici #(
  parameter int ESIK             = 25,
  parameter int SINDIRIM_PERIYOT = 3,
  parameter int SINDIRIM_MIKTAR  = 3
) (
  input  logic       saat,
  input  logic       reset,
  input  logic [3:0] istek,
  input  logic [2:0] porsiyon,
  input  logic       stok_yukle,
  input  logic [7:0] stok_deger,
  output logic [3:0] izin,
  output logic [3:0] tok,
  output logic [7:0] stok,
  output logic       bitti,
  output logic [7:0] bitme_sure
);

  localparam int FAZ_W = (SINDIRIM_PERIYOT > 1) ? $clog2(SINDIRIM_PERIYOT) : 1;
  localparam logic [FAZ_W-1:0] FAZ_SON = FAZ_W'(SINDIRIM_PERIYOT - 1);
  localparam logic [5:0] ESIK_6 = 6'(ESIK);
  localparam logic [4:0] MIKTAR_5 = 5'(SINDIRIM_MIKTAR);

  typedef enum logic [1:0] {BOS, DAGIT, SON} durum_t;

  durum_t           durum, durum_next;
  logic [3:0][4:0]  mide, mide_next;
  logic [1:0]       son_izin, son_izin_next;
  logic [FAZ_W-1:0] faz, faz_next;
  logic [3:0]       izin_next, tok_next;
  logic [7:0]       stok_next, bitme_sure_next;
  logic             bitti_next;

  logic [3:0] uygun;
  logic       bulundu;
  logic [1:0] aday, kazanan;
  logic [5:0] mide_toplam;
  logic [2:0] tuketilen;

  // Pool update: the consumed portion never exceeds the pool, so only the
  // upper bound needs saturation.
  function automatic logic [7:0] havuz_guncelle(input logic [7:0] s,
                                                input logic [2:0] t,
                                                input logic [7:0] e);
    logic [9:0] toplam;
    toplam = {2'b00, s} - {7'b0, t} + {2'b00, e};
    return (toplam > 10'd255) ? 8'hFF : toplam[7:0];
  endfunction

  // Digestion floors the stomach at zero.
  function automatic logic [4:0] sindir(input logic [4:0] m);
    return (m >= MIKTAR_5) ? (m - MIKTAR_5) : 5'd0;
  endfunction

  function automatic logic [7:0] sure_artir(input logic [7:0] s);
    return (s == 8'hFF) ? s : (s + 8'd1);
  endfunction

  // Stage boundary: combinational decision from current state and inputs
  always_comb begin
    durum_next      = durum;
    mide_next       = mide;
    son_izin_next   = son_izin;
    faz_next        = faz;
    izin_next       = 4'b0000;
    tok_next        = tok;
    stok_next       = stok;
    bitme_sure_next = bitme_sure;
    uygun           = istek & ~tok;
    bulundu         = 1'b0;
    aday            = 2'd0;
    kazanan         = son_izin;
    mide_toplam     = 6'd0;
    tuketilen       = 3'd0;

    // Round-robin search starting just after the last winner; k==4 wraps
    // back to the last winner itself, which is searched last.
    for (int k = 1; k <= 4; k++) begin
      aday = son_izin + 2'(k);
      if (!bulundu && uygun[aday]) begin
        bulundu = 1'b1;
        kazanan = aday;
      end
    end

    if (durum != SON) begin
      if (durum == DAGIT) begin
        if (bulundu && (porsiyon != 3'd0) && (stok >= {5'b0, porsiyon})) begin
          izin_next[kazanan] = 1'b1;
          son_izin_next      = kazanan;
          // Threshold uses the sum before any digestion this cycle.
          mide_toplam = {1'b0, mide[kazanan]} + {3'b000, porsiyon};
          if (mide_toplam >= ESIK_6) begin
            tok_next[kazanan] = 1'b1;
          end else begin
            mide_next[kazanan] = mide_toplam[4:0];
            tuketilen          = porsiyon;
          end
        end
        bitme_sure_next = sure_artir(bitme_sure);
        if (faz == FAZ_SON) begin
          faz_next = '0;
          for (int i = 0; i < 4; i++) begin
            if (!tok_next[i]) mide_next[i] = sindir(mide_next[i]);
          end
        end else begin
          faz_next = faz + FAZ_W'(1);
        end
      end

      stok_next = havuz_guncelle(stok, tuketilen, stok_yukle ? stok_deger : 8'd0);

      if (tok_next == 4'b1111) durum_next = SON;
      else if (stok_next != 8'd0) durum_next = DAGIT;
      else durum_next = BOS;
    end

    bitti_next = (tok_next == 4'b1111);
  end

  // Stage boundary: registered state and outputs
  always_ff @(posedge saat) begin
    if (reset) begin
      durum      <= BOS;
      mide       <= '0;
      son_izin   <= 2'd3;
      faz        <= '0;
      izin       <= 4'b0000;
      tok        <= 4'b0000;
      stok       <= 8'd0;
      bitti      <= 1'b0;
      bitme_sure <= 8'd0;
    end else begin
      durum      <= durum_next;
      mide       <= mide_next;
      son_izin   <= son_izin_next;
      faz        <= faz_next;
      izin       <= izin_next;
      tok        <= tok_next;
      stok       <= stok_next;
      bitti      <= bitti_next;
      bitme_sure <= bitme_sure_next;
    end
  end

endmodule

// File: tb/tb_balik_dagitici.sv
module tb_balik_dagitici;

  localparam int ESIK = 25;
  localparam int PER  = 3;
  localparam int MIK  = 3;

  logic       saat = 1'b0;
  logic       reset;
  logic [3:0] istek;
  logic [2:0] porsiyon;
  logic       stok_yukle;
  logic [7:0] stok_deger;
  logic [3:0] izin;
  logic [3:0] tok;
  logic [7:0] stok;
  logic       bitti;
  logic [7:0] bitme_sure;

  int n_cmp = 0;
  int n_err = 0;

  balik_dagitici #(.ESIK(ESIK), .SINDIRIM_PERIYOT(PER), .SINDIRIM_MIKTAR(MIK)) dut (
    .saat(saat), .reset(reset), .istek(istek), .porsiyon(porsiyon),
    .stok_yukle(stok_yukle), .stok_deger(stok_deger), .izin(izin), .tok(tok),
    .stok(stok), .bitti(bitti), .bitme_sure(bitme_sure)
  );

  always #5 saat = ~saat;

  function automatic void kontrol(string ad, int got, int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", ad, got, want, $time);
    end
  endfunction

  // Reference model: plain integer bookkeeping of pool, stomachs and flags.
  int  m_izin, m_stok, m_sure, m_son, m_faz;
  int  m_mide [4];
  bit  m_tok [4];
  bit  m_dagit, m_bitti, m_aktif = 1'b0;

  function automatic int tok_deger();
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_tok[i]) v += (1 << i);
    return v;
  endfunction

  task automatic model_adim(input bit r, input int ist, input int p, input bit y, input int d);
    int used, j, w;
    if (r) begin
      m_izin = 0; m_stok = 0; m_sure = 0; m_son = 3; m_faz = 0;
      for (int i = 0; i < 4; i++) begin m_mide[i] = 0; m_tok[i] = 0; end
      m_dagit = 0; m_bitti = 0; m_aktif = 1;
    end else if (m_aktif) begin
      m_izin = 0;
      if (!m_bitti) begin
        used = 0;
        if (m_dagit) begin
          w = -1;
          for (int k = 1; k <= 4; k++) begin
            j = (m_son + k) % 4;
            if (w < 0 && ist[j] && !m_tok[j]) w = j;
          end
          if (w >= 0 && p > 0 && m_stok >= p) begin
            m_izin = 1 << w;
            m_son = w;
            if (m_mide[w] + p >= ESIK) m_tok[w] = 1;
            else begin m_mide[w] += p; used = p; end
          end
          if (m_sure < 255) m_sure++;
          if (m_faz == PER - 1)
            for (int i = 0; i < 4; i++)
              if (!m_tok[i]) m_mide[i] = (m_mide[i] > MIK) ? m_mide[i] - MIK : 0;
          m_faz = (m_faz + 1) % PER;
        end
        m_stok = m_stok - used + (y ? d : 0);
        if (m_stok > 255) m_stok = 255;
        if (tok_deger() == 15) m_bitti = 1;
        else m_dagit = (m_stok != 0);
      end
    end
  endtask

  // Single compare process: advance the model with the inputs seen at the
  // edge, then check the registered outputs shortly after it.
  always @(posedge saat) begin
    model_adim(reset, int'(istek), int'(porsiyon), stok_yukle, int'(stok_deger));
    #1;
    if (m_aktif) begin
      kontrol("model izin", int'(izin), m_izin);
      kontrol("model tok", int'(tok), tok_deger());
      kontrol("model stok", int'(stok), m_stok);
      kontrol("model bitti", int'(bitti), int'(m_bitti));
      kontrol("model bitme_sure", int'(bitme_sure), m_sure);
    end
  end

  task automatic cyc(input logic [3:0] i, input logic [2:0] p, input logic y, input logic [7:0] d);
    istek = i; porsiyon = p; stok_yukle = y; stok_deger = d;
    @(posedge saat);
    #2;
  endtask

  task automatic sifirla();
    reset = 1'b1;
    cyc(4'h0, 3'd0, 1'b0, 8'd0);
    reset = 1'b0;
  endtask

  int izin_bek [5] = '{1, 2, 4, 8, 1};
  int stok_bek [5] = '{95, 90, 85, 80, 75};
  int s_stok, s_sure, sayac;

  initial begin
    reset = 1'b1; istek = 4'h0; porsiyon = 3'd0; stok_yukle = 1'b0; stok_deger = 8'd0;

    // Reset state
    sifirla();
    kontrol("reset izin", int'(izin), 0);
    kontrol("reset tok", int'(tok), 0);
    kontrol("reset stok", int'(stok), 0);
    kontrol("reset bitti", int'(bitti), 0);
    kontrol("reset bitme_sure", int'(bitme_sure), 0);

    // Round-robin over all four penguins
    cyc(4'hF, 3'd5, 1'b1, 8'd100);
    kontrol("rr load stok", int'(stok), 100);
    kontrol("rr load izin", int'(izin), 0);
    for (int k = 0; k < 5; k++) begin
      cyc(4'hF, 3'd5, 1'b0, 8'd0);
      kontrol("rr izin", int'(izin), izin_bek[k]);
      kontrol("rr stok", int'(stok), stok_bek[k]);
    end
    kontrol("rr bitme_sure", int'(bitme_sure), 5);

    // Single penguin with digestion, full on fourth grant
    sifirla();
    cyc(4'h1, 3'd7, 1'b1, 8'd200);
    cyc(4'h1, 3'd7, 1'b0, 8'd0);
    kontrol("mide stok1", int'(stok), 193);
    cyc(4'h1, 3'd7, 1'b0, 8'd0);
    kontrol("mide stok2", int'(stok), 186);
    cyc(4'h1, 3'd7, 1'b0, 8'd0);
    kontrol("mide stok3", int'(stok), 179);
    kontrol("mide tok3", int'(tok), 0);
    cyc(4'h1, 3'd7, 1'b0, 8'd0);
    kontrol("mide tok4", int'(tok), 1);
    kontrol("mide izin4", int'(izin), 1);
    kontrol("mide stok4", int'(stok), 179);
    kontrol("mide bitti", int'(bitti), 0);

    // Pool exhaustion and return to empty state
    sifirla();
    cyc(4'h3, 3'd4, 1'b1, 8'd8);
    cyc(4'h3, 3'd4, 1'b0, 8'd0);
    kontrol("bos izin1", int'(izin), 1);
    kontrol("bos stok1", int'(stok), 4);
    cyc(4'h3, 3'd4, 1'b0, 8'd0);
    kontrol("bos izin2", int'(izin), 2);
    kontrol("bos stok2", int'(stok), 0);
    cyc(4'h3, 3'd4, 1'b0, 8'd0);
    kontrol("bos izin3", int'(izin), 0);
    cyc(4'h3, 3'd4, 1'b1, 8'd4);
    kontrol("bos reload izin", int'(izin), 0);
    cyc(4'h3, 3'd4, 1'b0, 8'd0);
    kontrol("bos after reload izin", int'(izin), 1);
    kontrol("bos after reload stok", int'(stok), 0);

    // Grant and load in the same cycle
    sifirla();
    cyc(4'h1, 3'd5, 1'b1, 8'd5);
    cyc(4'h1, 3'd5, 1'b1, 8'd20);
    kontrol("ayni izin", int'(izin), 1);
    kontrol("ayni stok", int'(stok), 20);
    cyc(4'h0, 3'd0, 1'b0, 8'd0);
    kontrol("ayni still dagit", int'(bitme_sure), 2);

    // Fill everyone until finished
    sifirla();
    cyc(4'hF, 3'd7, 1'b1, 8'd255);
    sayac = 0;
    while (!bitti && sayac < 300) begin
      cyc(4'hF, 3'd7, 1'b1, 8'd7);
      sayac++;
    end
    kontrol("son reached", int'(bitti), 1);
    kontrol("son tok", int'(tok), 15);
    s_stok = int'(stok);
    s_sure = int'(bitme_sure);
    cyc(4'hF, 3'd7, 1'b1, 8'd50);
    kontrol("son izin", int'(izin), 0);
    kontrol("son stok frozen", int'(stok), s_stok);
    kontrol("son sure frozen", int'(bitme_sure), s_sure);
    kontrol("son bitti held", int'(bitti), 1);

    // Reset in the middle of distribution
    sifirla();
    cyc(4'hF, 3'd3, 1'b1, 8'd50);
    cyc(4'hF, 3'd3, 1'b0, 8'd0);
    cyc(4'hF, 3'd3, 1'b0, 8'd0);
    reset = 1'b1;
    cyc(4'hF, 3'd3, 1'b1, 8'd50);
    reset = 1'b0;
    kontrol("mid rst izin", int'(izin), 0);
    kontrol("mid rst stok", int'(stok), 0);
    kontrol("mid rst sure", int'(bitme_sure), 0);
    cyc(4'hF, 3'd3, 1'b1, 8'd50);
    cyc(4'hF, 3'd3, 1'b0, 8'd0);
    kontrol("mid rst first grant", int'(izin), 1);

    // Randomized traffic, checked by the compare process
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 399) == 0);
      cyc(4'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
          8'($urandom_range(0, 255)));
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
